// File: rtl/mel_frame_buffer.sv
// mel_frame_buffer: collects the MEL band energies of one frame into a
// ping-pong register buffer and exposes the completed bank to a reader.
module mel_frame_buffer #(
  parameter int unsigned N_MEL           = 32,
  parameter int unsigned DATAOUT_WIDTH   = 16,
  parameter int unsigned FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_en_inf_system_sync,
  input  logic                       even_mel_valid,
  input  logic                       odd_mel_valid,
  input  logic [DATAOUT_WIDTH-1:0]   mel_value,
  output logic                       frame_valid,
  output logic                       rd_bank,
  input  logic                       rd_en,
  input  logic [$clog2(N_MEL)-1:0]   rd_addr,
  output logic [DATAOUT_WIDTH-1:0]   rd_data,
  output logic                       rd_data_valid,
  input  logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       overflow,
  output logic                       seq_err
);

  localparam int unsigned HALF   = N_MEL / 2;
  localparam int unsigned CNT_W  = $clog2(HALF) + 1;
  localparam int unsigned ADDR_W = $clog2(N_MEL);

  logic [DATAOUT_WIDTH-1:0]   mem_q [2][N_MEL];

  logic [CNT_W-1:0]           even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0]           odd_cnt_q, odd_cnt_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic                       frame_valid_q, frame_valid_d;
  logic [DATAOUT_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                       rd_data_valid_q, rd_data_valid_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       overflow_q, overflow_d;
  logic                       seq_err_q, seq_err_d;

  logic                       en_c;
  logic                       even_req_c, odd_req_c;
  logic                       even_full_c, odd_full_c;
  logic                       even_wr_c, odd_wr_c;
  logic                       final_wr_c;
  logic [ADDR_W-1:0]          wr_addr_c;

  // Strobe qualification: even wins a collision, full counters reject strobes.
  assign en_c        = spi_en_inf_system_sync;
  assign even_req_c  = en_c & even_mel_valid;
  assign odd_req_c   = en_c & odd_mel_valid;
  assign even_full_c = (even_cnt_q == CNT_W'(HALF));
  assign odd_full_c  = (odd_cnt_q == CNT_W'(HALF));
  assign even_wr_c   = even_req_c & ~even_full_c;
  assign odd_wr_c    = odd_req_c & ~even_req_c & ~odd_full_c;
  assign wr_addr_c   = even_wr_c ? ADDR_W'({even_cnt_q, 1'b0})
                                 : ADDR_W'({odd_cnt_q, 1'b1});

  // Next-state: fill counters, frame completion/swap, release, read, flags.
  always_comb begin
    even_cnt_d      = even_cnt_q;
    odd_cnt_d       = odd_cnt_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    frame_valid_d   = frame_valid_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    frame_cnt_d     = frame_cnt_q;
    overflow_d      = overflow_q;
    seq_err_d       = seq_err_q;
    final_wr_c      = 1'b0;

    if ((even_req_c & odd_req_c) | (even_req_c & even_full_c) |
        (odd_req_c & odd_full_c)) begin
      seq_err_d = 1'b1;
    end

    even_cnt_d = even_cnt_q + CNT_W'(even_wr_c);
    odd_cnt_d  = odd_cnt_q + CNT_W'(odd_wr_c);
    final_wr_c = (even_wr_c | odd_wr_c) &
                 (even_cnt_d == CNT_W'(HALF)) & (odd_cnt_d == CNT_W'(HALF));

    // Reads always use the pre-swap bank.
    if (en_c & rd_en & frame_valid_q) begin
      rd_data_d       = mem_q[rd_bank_q][rd_addr];
      rd_data_valid_d = 1'b1;
    end

    if (final_wr_c) begin
      even_cnt_d = '0;
      odd_cnt_d  = '0;
      if (!frame_valid_q || frame_done) begin
        rd_bank_d     = wr_bank_q;
        wr_bank_d     = ~wr_bank_q;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + FRAME_CNT_WIDTH'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (en_c & frame_done & frame_valid_q) begin
      frame_valid_d = 1'b0;
    end

    // Soft clear returns all control state to its reset values.
    if (!en_c) begin
      even_cnt_d      = '0;
      odd_cnt_d       = '0;
      wr_bank_d       = 1'b0;
      rd_bank_d       = 1'b0;
      frame_valid_d   = 1'b0;
      rd_data_d       = '0;
      rd_data_valid_d = 1'b0;
      frame_cnt_d     = '0;
      overflow_d      = 1'b0;
      seq_err_d       = 1'b0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      even_cnt_q      <= '0;
      odd_cnt_q       <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      frame_valid_q   <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      frame_cnt_q     <= '0;
      overflow_q      <= 1'b0;
      seq_err_q       <= 1'b0;
    end else begin
      even_cnt_q      <= even_cnt_d;
      odd_cnt_q       <= odd_cnt_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      frame_valid_q   <= frame_valid_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      frame_cnt_q     <= frame_cnt_d;
      overflow_q      <= overflow_d;
      seq_err_q       <= seq_err_d;
    end
  end

  // Band storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && (even_wr_c || odd_wr_c)) begin
      mem_q[wr_bank_q][wr_addr_c] <= mel_value;
    end
  end

  assign frame_valid   = frame_valid_q;
  assign rd_bank       = rd_bank_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign frame_cnt     = frame_cnt_q;
  assign overflow      = overflow_q;
  assign seq_err       = seq_err_q;

endmodule
